gpi_pad_rx_conditioner: RTL and testbench
=========================================

// Module: gpi_pad_rx_conditioner
// PURPOSE
//  Digital receive-side companion to the EG1D80V GPO pad drivers: conditions the pad receiver output (DI_I)
//  into the core clock domain. Performs sync, glitch filtering, edge detect and a sticky IRQ.
//  Also drives the pad's input-enable and pull controls. Sits between the IO ring and the GPIO register block.
// PARAMETERS
//  SYNC_STAGES  2   synchronizer flop count on DI_I (legal 2..4)
//  FILT_W       8   width of glitch-filter threshold/counter
//  RESET_LEVEL  0   LEVEL_O value in reset and while disabled
// PORTS
//  CLK_I        in   1       core clock
//  RSTN_I       in   1       async active-low reset
//  EN_I         in   1       receiver enable
//  FILT_I       in   FILT_W  filter threshold in cycles (0 = no filtering)
//  PULL_I       in   2       00 none, 01 pull-down, 10 pull-up, 11 pull-up
//  IRQ_MASK_I   in   2       [0] rise enables IRQ, [1] fall enables IRQ
//  IRQ_CLR_I    in   1       clear sticky IRQ (1-cycle pulse)
//  DI_I         in   1       asynchronous pad receiver output
//  IE_O         out  1       pad input-enable
//  PE_O         out  1       pad pull-enable
//  PS_O         out  1       pad pull-select (1 = up)
//  LEVEL_O      out  1       filtered level
//  RISE_O       out  1       1-cycle pulse on accepted 0->1
//  FALL_O       out  1       1-cycle pulse on accepted 1->0
//  IRQ_O        out  1       sticky interrupt
// BEHAVIOUR
//  Reset: state=OFF; IE_O, PE_O, PS_O, RISE_O, FALL_O, IRQ_O = 0; LEVEL_O = RESET_LEVEL; sync chain = 0.
//  All outputs are registered. PE_O = |PULL_I and PS_O = PULL_I[1], registered; independent of EN_I.
//  syncd = DI_I after SYNC_STAGES flops. FSM: OFF, SETTLE, STABLE, PEND. 8-bit-style counter cnt[FILT_W-1:0].
//  - OFF: IE_O=0. EN_I=1 -> SETTLE with cnt=0; IE_O=1 from the next cycle.
//  - SETTLE: counts SYNC_STAGES+2 cycles. Then LEVEL_O<=syncd, -> STABLE. No RISE/FALL pulse.
//  - STABLE: syncd!=LEVEL_O: if FILT_I==0, flip LEVEL_O with a pulse next edge; else -> PEND, cnt=1.
//  - PEND: syncd==LEVEL_O -> STABLE, cnt=0 (glitch rejected, no pulse).
//    Else if cnt>=FILT_I -> flip LEVEL_O, pulse, -> STABLE. Else cnt++ (saturates at all-ones).
//  - FILT_I is sampled live. Lowering it mid-PEND accepts at the next edge where cnt>=FILT_I.
//  Latency: DI_I step to LEVEL_O/pulse = SYNC_STAGES+FILT_I+1 CLK_I edges.
//    Requires syncd to differ for FILT_I+1 consecutive samples.
//  RISE_O/FALL_O coincide with the LEVEL_O update cycle; never both in one cycle.
//  EN_I=0 in any state -> OFF next edge: LEVEL_O=RESET_LEVEL, cnt=0, no pulse; IRQ_O is retained.
//  IRQ_O set when (RISE_O&IRQ_MASK_I[0])|(FALL_O&IRQ_MASK_I[1]). Cleared by IRQ_CLR_I.
//    Set and clear in the same cycle -> IRQ_O stays 1.
//  RSTN_I asserted mid-operation -> immediate return to reset values, pending filter discarded.
// CONFIGURATION
//  GPI_RX_EDGE_CNT_EN defined:
//  - adds port EDGE_CNT_O out 16: count of accepted edges (rise and fall).
//  - Reset 0; increments with each RISE_O/FALL_O; wraps 0xFFFF->0x0000.
//  - IRQ_CLR_I clears it; clear plus edge in the same cycle -> 1.
//  - Not cleared by EN_I=0.
//  Undefined: the port and counter are absent. All other behaviour is identical.
// TESTING
//  1 Reset: RSTN_I=0 with DI_I=1 -> all outputs 0, LEVEL_O=RESET_LEVEL; no pulses after release with EN_I=0.
//  2 Enable: EN_I=1, DI_I=1, FILT_I=0
//    -> IE_O=1 after 1 edge, LEVEL_O=1 after SETTLE (5 edges w/ SYNC=2), RISE_O never pulses.
//  3 Filter: FILT_I=4, DI_I 0->1 held -> RISE_O at edge 7 (2+4+1), IRQ_O=1 if MASK[0]=1.
//    A 4-cycle DI_I high glitch -> no pulse, LEVEL_O stays 0.
//  4 IRQ: IRQ_CLR_I coincident with FALL_O and MASK=2'b10 -> IRQ_O=1. A later clear alone -> 0.
//  5 Disable mid-PEND: FILT_I=10, EN_I=0 at cnt=5 -> OFF, IE_O=0, LEVEL_O=0, no pulse.
//    Re-enable -> SETTLE without an edge.
//  6 (GPI_RX_EDGE_CNT_EN) 65537 accepted edges -> EDGE_CNT_O=1. Clear during an edge -> 1.

Source files
------------

// File: rtl/gpi_pad_rx_if.sv
// +----------------------------------------------------------------------------+
// | gpi_pad_rx_if : control/status bundle between GPIO regs, pad and receiver  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface gpi_pad_rx_if #(
  parameter int FILT_W = 8
);
  logic              EN_I;
  logic [FILT_W-1:0] FILT_I;
  logic [1:0]        PULL_I;
  logic [1:0]        IRQ_MASK_I;
  logic              IRQ_CLR_I;
  logic              DI_I;
  logic              IE_O;
  logic              PE_O;
  logic              PS_O;
  logic              LEVEL_O;
  logic              RISE_O;
  logic              FALL_O;
  logic              IRQ_O;

  modport slave (
    input  EN_I, FILT_I, PULL_I, IRQ_MASK_I, IRQ_CLR_I, DI_I,
    output IE_O, PE_O, PS_O, LEVEL_O, RISE_O, FALL_O, IRQ_O
  );

  modport master (
    output EN_I, FILT_I, PULL_I, IRQ_MASK_I, IRQ_CLR_I, DI_I,
    input  IE_O, PE_O, PS_O, LEVEL_O, RISE_O, FALL_O, IRQ_O
  );
endinterface

`default_nettype wire

// File: rtl/gpi_pad_rx_conditioner.sv
// +----------------------------------------------------------------------------+
// | gpi_pad_rx_conditioner : pad input sync, glitch filter, edge detect, IRQ   |
// | Optional edge counter on EDGE_CNT_O when GPI_RX_EDGE_CNT_EN is defined.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module gpi_pad_rx_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  wire logic   CLK_I,
  input  wire logic   RSTN_I,
  gpi_pad_rx_if.slave bus
`ifdef GPI_RX_EDGE_CNT_EN
  ,
  output logic [15:0] EDGE_CNT_O
`endif
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_STABLE = 2'd2,
    ST_PEND   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   ie_q, ie_d;
  logic                   pe_q, pe_d;
  logic                   ps_q, ps_d;
  logic                   irq_q, irq_d;
  logic                   syncd;

  assign syncd = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], bus.DI_I};
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    if (!bus.EN_I) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      level_d = RESET_LEVEL;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
        // Wait for the synchronizer to flush before adopting the pad level silently.
        ST_SETTLE: begin
          if (cnt_q == FILT_W'(SYNC_STAGES + 1)) begin
            level_d = syncd;
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + FILT_W'(1);
          end
        end
        ST_STABLE: begin
          if (syncd != level_q) begin
            if (bus.FILT_I == '0) begin
              level_d = syncd;
              rise_d  = syncd;
              fall_d  = ~syncd;
            end else begin
              state_d = ST_PEND;
              cnt_d   = FILT_W'(1);
            end
          end
        end
        ST_PEND: begin
          if (syncd == level_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q >= bus.FILT_I) begin
            level_d = syncd;
            rise_d  = syncd;
            fall_d  = ~syncd;
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (~&cnt_q) begin
            cnt_d = cnt_q + FILT_W'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end

    ie_d  = (state_d != ST_OFF);
    pe_d  = |bus.PULL_I;
    ps_d  = bus.PULL_I[1];
    // A clear coinciding with a new qualifying edge must not lose that edge.
    irq_d = (rise_q & bus.IRQ_MASK_I[0]) | (fall_q & bus.IRQ_MASK_I[1]) |
            (irq_q & ~bus.IRQ_CLR_I);
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      sync_q  <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      ie_q    <= 1'b0;
      pe_q    <= 1'b0;
      ps_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      ie_q    <= ie_d;
      pe_q    <= pe_d;
      ps_q    <= ps_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.IE_O    = ie_q;
  assign bus.PE_O    = pe_q;
  assign bus.PS_O    = ps_q;
  assign bus.LEVEL_O = level_q;
  assign bus.RISE_O  = rise_q;
  assign bus.FALL_O  = fall_q;
  assign bus.IRQ_O   = irq_q;

`ifdef GPI_RX_EDGE_CNT_EN
  logic [15:0] edge_cnt_q, edge_cnt_d;

  always_comb begin
    if (bus.IRQ_CLR_I) begin
      edge_cnt_d = {15'd0, rise_q | fall_q};
    end else begin
      edge_cnt_d = edge_cnt_q + {15'd0, rise_q | fall_q};
    end
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign EDGE_CNT_O = edge_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpi_pad_rx_conditioner.sv
// Scoreboard bench for gpi_pad_rx_conditioner (SYNC_STAGES=2, FILT_W=8, RESET_LEVEL=0).
`timescale 1ns/1ps
`default_nettype none

module tb_gpi_pad_rx_conditioner;

  typedef struct {
    bit rise;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   bulk = 1'b0;
  int   bulk_cnt = 0;
  exp_t exp_q[$];

  gpi_pad_rx_if #(.FILT_W(8)) bus ();

`ifdef GPI_RX_EDGE_CNT_EN
  logic [15:0] edge_cnt;
`endif

  gpi_pad_rx_conditioner #(
    .SYNC_STAGES(2),
    .FILT_W     (8),
    .RESET_LEVEL(1'b0)
  ) dut (
    .CLK_I (clk),
    .RSTN_I(rst_n),
    .bus   (bus)
`ifdef GPI_RX_EDGE_CNT_EN
    ,
    .EDGE_CNT_O(edge_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_edge(input bit rise, input int at);
    exp_t e;
    e.rise = rise;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic clr_pulse();
    bus.IRQ_CLR_I = 1'b1;
    tick(1);
    bus.IRQ_CLR_I = 1'b0;
  endtask

  // Monitor: every pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.RISE_O || bus.FALL_O)) begin
      if (bulk) begin
        bulk_cnt++;
        if (bus.RISE_O && bus.FALL_O) begin
          vectors++;
          miscompares++;
          $display("FAIL bulk_both_pulses at cycle %0d: got rise=1 fall=1, expected one", cyc);
        end
      end else if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse at cycle %0d: got rise=%0b fall=%0b, expected none",
                 cyc, bus.RISE_O, bus.FALL_O);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (bus.RISE_O !== e.rise || bus.FALL_O !== !e.rise || cyc != e.cyc ||
            bus.LEVEL_O !== e.rise) begin
          miscompares++;
          $display("FAIL edge_pulse: got rise=%0b fall=%0b level=%0b at cycle %0d, expected rise=%0b at cycle %0d",
                   bus.RISE_O, bus.FALL_O, bus.LEVEL_O, cyc, e.rise, e.cyc);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    bus.EN_I       = 1'b0;
    bus.FILT_I     = 8'd0;
    bus.PULL_I     = 2'b10;
    bus.IRQ_MASK_I = 2'b00;
    bus.IRQ_CLR_I  = 1'b0;
    bus.DI_I       = 1'b1;

    // Reset with DI high and a pull request: everything held at reset value.
    tick(3);
    chk("reset_outputs", {25'd0, bus.IE_O, bus.PE_O, bus.PS_O, bus.LEVEL_O,
                          bus.RISE_O, bus.FALL_O, bus.IRQ_O}, 32'd0);
    rst_n = 1'b1;
    tick(4);
    chk("disabled_pull_up", {29'd0, bus.IE_O, bus.PE_O, bus.PS_O}, 32'b011);
    chk("disabled_level", {31'd0, bus.LEVEL_O}, 32'd0);
    bus.PULL_I = 2'b01;
    tick(1);
    chk("pull_down", {30'd0, bus.PE_O, bus.PS_O}, 32'b10);
    bus.PULL_I = 2'b00;
    tick(1);
    chk("pull_none", {30'd0, bus.PE_O, bus.PS_O}, 32'b00);

    // Enable with DI high: IE after one edge, level adopted after settle, no pulse.
    bus.EN_I = 1'b1;
    tick(1);
    chk("enable_ie", {31'd0, bus.IE_O}, 32'd1);
    chk("settle_level_early", {31'd0, bus.LEVEL_O}, 32'd0);
    tick(3);
    chk("settle_level_edge4", {31'd0, bus.LEVEL_O}, 32'd0);
    tick(1);
    chk("settle_level_edge5", {31'd0, bus.LEVEL_O}, 32'd1);

    // Unfiltered fall, then filtered rise with latency 2+4+1.
    bus.DI_I = 1'b0; k = cyc; expect_edge(1'b0, k + 3);
    tick(5);
    chk("level_after_fall", {31'd0, bus.LEVEL_O}, 32'd0);
    bus.IRQ_MASK_I = 2'b01;
    bus.FILT_I     = 8'd4;
    bus.DI_I = 1'b1; k = cyc; expect_edge(1'b1, k + 7);
    tick(6);
    chk("filt_level_edge6", {31'd0, bus.LEVEL_O}, 32'd0);
    tick(1);
    chk("filt_level_edge7", {31'd0, bus.LEVEL_O}, 32'd1);
    tick(1);
    chk("irq_rise_masked_in", {31'd0, bus.IRQ_O}, 32'd1);
    clr_pulse();
    chk("irq_cleared", {31'd0, bus.IRQ_O}, 32'd0);
    bus.DI_I = 1'b0; k = cyc; expect_edge(1'b0, k + 7);
    tick(9);
    chk("irq_fall_masked_out", {31'd0, bus.IRQ_O}, 32'd0);

    // 4-cycle high glitch rejected; 5-cycle high accepted then released.
    bus.DI_I = 1'b1;
    tick(4);
    bus.DI_I = 1'b0;
    tick(8);
    chk("glitch_level", {31'd0, bus.LEVEL_O}, 32'd0);
    chk("glitch_irq", {31'd0, bus.IRQ_O}, 32'd0);
    bus.DI_I = 1'b1; k = cyc;
    expect_edge(1'b1, k + 7);
    expect_edge(1'b0, k + 12);
    tick(5);
    bus.DI_I = 1'b0;
    tick(9);
    chk("pulse5_level", {31'd0, bus.LEVEL_O}, 32'd0);
    chk("pulse5_irq", {31'd0, bus.IRQ_O}, 32'd1);
    clr_pulse();

    // Clear coincident with a masked-in fall keeps IRQ; a lone clear drops it.
    bus.IRQ_MASK_I = 2'b10;
    bus.FILT_I     = 8'd0;
    bus.DI_I = 1'b1; k = cyc; expect_edge(1'b1, k + 3);
    tick(5);
    chk("irq_rise_masked_out", {31'd0, bus.IRQ_O}, 32'd0);
    bus.DI_I = 1'b0; k = cyc; expect_edge(1'b0, k + 3);
    tick(3);
    clr_pulse();
    chk("irq_set_and_clear", {31'd0, bus.IRQ_O}, 32'd1);
`ifdef GPI_RX_EDGE_CNT_EN
    chk("edge_cnt_clear_with_edge", {16'd0, edge_cnt}, 32'd1);
`endif
    tick(2);
    clr_pulse();
    chk("irq_clear_alone", {31'd0, bus.IRQ_O}, 32'd0);
`ifdef GPI_RX_EDGE_CNT_EN
    chk("edge_cnt_clear_alone", {16'd0, edge_cnt}, 32'd0);
`endif

    // Disable mid-filter: level forced to reset value, IRQ retained, no pulse.
    bus.IRQ_MASK_I = 2'b11;
    bus.DI_I = 1'b1; k = cyc; expect_edge(1'b1, k + 3);
    tick(5);
    chk("pre_disable_irq", {31'd0, bus.IRQ_O}, 32'd1);
    bus.FILT_I = 8'd10;
    bus.DI_I   = 1'b0;
    tick(7);
    bus.EN_I = 1'b0;
    tick(1);
    chk("disable_ie_level_irq", {29'd0, bus.IE_O, bus.LEVEL_O, bus.IRQ_O}, 32'b001);
    tick(15);
    bus.EN_I = 1'b1;
    tick(1);
    chk("reenable_ie", {31'd0, bus.IE_O}, 32'd1);
    tick(4);
    chk("reenable_level", {31'd0, bus.LEVEL_O}, 32'd0);
    clr_pulse();

    // Async reset mid-filter discards the pending edge.
    bus.DI_I = 1'b1;
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {28'd0, bus.IE_O, bus.LEVEL_O, bus.IRQ_O, bus.RISE_O}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(20);
    chk("post_reset_level", {31'd0, bus.LEVEL_O}, 32'd1);

`ifdef GPI_RX_EDGE_CNT_EN
    // 65537 accepted edges wrap the 16-bit counter to 1.
    bus.FILT_I     = 8'd0;
    bus.IRQ_MASK_I = 2'b00;
    clr_pulse();
    chk("edge_cnt_zero", {16'd0, edge_cnt}, 32'd0);
    bulk = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      bus.DI_I = ~bus.DI_I;
      tick(1);
    end
    tick(5);
    bulk = 1'b0;
    chk("bulk_pulses", bulk_cnt, 32'd65537);
    chk("edge_cnt_wrap", {16'd0, edge_cnt}, 32'd1);
    chk("bulk_level", {31'd0, bus.LEVEL_O}, 32'd0);
`endif

    tick(3);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
